if_fetch: RTL and testbench

- Instruction-fetch stage. Consumes the PC stream produced by the PC register (pc, right_one flag) and issues single-word reads to the instruction memory port over a req/ack handshake.
- Delivers fetched instructions, each tagged with its PC, to the IF/ID pipeline register.
- Raises a stall request while a fetch is outstanding.
- On branch redirect, squashes wrong-path fetches and discards stale PCs until the redirect target arrives.

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_fetch_hold_buf.sv | 39 +++
 rtl/if_fetch.sv | 128 ++++++++++++
 tb/tb_if_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Instruction-fetch stage shared types.
// State encoding and default widths.
package if_fetch_pkg;
  localparam int ADDR_W_D   = 32;
  localparam int INST_W_D   = 32;
  localparam int STALL_IF_D = 1;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_BUSY = 2'd1,
    IF_KILL = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;
endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry buffer parking a fetched word
// while the IF stage is stalled downstream.
module if_fetch_hold_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_rel,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_clr || i_rel) begin
      r_valid <= 1'b0;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch.sv
// IF stage: single-outstanding imem fetch with
// branch squash and downstream-stall hold.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int INST_W   = INST_W_D,
  parameter int STALL_IF = STALL_IF_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              br,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              right_one_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              stallreq_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);
  if_state_e         r_state;
  if_state_e         w_next;
  logic              r_wait_tgt;
  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;

  logic              w_st;
  logic              w_busy;
  logic              w_latch;
  logic              w_ack_ok;
  logic              w_load;
  logic              w_rel;
  logic              w_clr;
  logic              w_dlv;
  logic [INST_W-1:0] w_dword;
  logic [ADDR_W-1:0] w_dpc;
  logic [INST_W-1:0] w_hb_inst;
  logic [ADDR_W-1:0] w_hb_pc;
  logic              w_hb_valid;

  assign w_st     = stall[STALL_IF];
  assign w_busy   = (r_state == IF_BUSY);
  assign w_latch  = (r_state == IF_IDLE) && !br &&
                    (!r_wait_tgt || right_one_i);
  assign w_ack_ok = w_busy && mem_ack_i && !br;
  assign w_load   = w_ack_ok && w_st;
  assign w_rel    = w_hb_valid && !br && !w_st;
  assign w_clr    = w_hb_valid && br;
  assign w_dlv    = (w_ack_ok && !w_st) || w_rel;
  assign w_dword  = w_hb_valid ? w_hb_inst : mem_rdata_i;
  assign w_dpc    = w_hb_valid ? w_hb_pc : r_addr;

  if_fetch_hold_buf #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_clr  (w_clr),
    .i_rel  (w_rel),
    .i_inst (mem_rdata_i),
    .i_pc   (r_addr),
    .o_inst (w_hb_inst),
    .o_pc   (w_hb_pc),
    .o_valid(w_hb_valid)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IF_IDLE: if (w_latch) w_next = IF_BUSY;
      IF_BUSY: begin
        if (mem_ack_i)
          w_next = (!br && w_st) ? IF_HOLD : IF_IDLE;
        else if (br)
          w_next = IF_KILL;
      end
      IF_KILL: if (mem_ack_i) w_next = IF_IDLE;
      IF_HOLD: if (br || !w_st) w_next = IF_IDLE;
      default: w_next = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IF_IDLE;
      r_wait_tgt <= 1'b0;
      r_addr     <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch)
        r_addr <= pc_i;
      // stale PCs after a redirect are ignored until the target shows up
      if (br)
        r_wait_tgt <= 1'b1;
      else if (w_latch)
        r_wait_tgt <= 1'b0;
      if (br) begin
        r_valid <= 1'b0;
      end else if (!w_st) begin
        r_valid <= w_dlv;
        if (w_dlv) begin
          r_inst    <= w_dword;
          r_inst_pc <= w_dpc;
        end
      end
    end
  end

  assign mem_req_o    = w_busy || (r_state == IF_KILL);
  assign mem_addr_o   = r_addr;
  assign stallreq_o   = (w_busy && !mem_ack_i) ||
                        (r_state == IF_KILL) ||
                        (r_state == IF_HOLD);
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_valid_o = r_valid;
endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a
// transaction-level model of the fetch stage.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] pc_i;
  logic        right_one_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stallreq_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br          (br),
    .pc_i        (pc_i),
    .right_one_i (right_one_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stallreq_o  (stallreq_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_valid_o(inst_valid_o)
  );

  int total = 0;
  int bad   = 0;

  // model: one outstanding fetch, an optional parked word
  bit          m_out, m_dead, m_held, m_wait;
  logic [31:0] m_addr, m_hw, m_hp;
  logic [31:0] m_inst, m_pc;
  bit          m_valid;
  int          mem_cnt, mem_dly;
  logic [31:0] mem_data;
  bit          chk_en = 0;
  bit          last_stallreq;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit b, input logic [5:0] s,
                      input logic [31:0] p, input bit o1);
    bit          ack, dlv, st;
    logic [31:0] rd, dw, dp;
    @(negedge clk);
    ack = !r && m_out && (mem_cnt + 1 == mem_dly);
    rd  = ack ? mem_data : $urandom;
    rst = r; br = b; stall = s; pc_i = p; right_one_i = o1;
    mem_ack_i = ack; mem_rdata_i = rd;
    #1;
    last_stallreq = stallreq_o;
    if (chk_en) begin
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_out});
      chk("mem_addr", mem_addr_o, m_addr);
      chk("stallreq", {31'd0, stallreq_o},
          {31'd0, m_held || (m_out && (m_dead || !ack))});
      chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
      chk("inst", inst_o, m_inst);
      chk("inst_pc", inst_pc_o, m_pc);
    end
    dlv = 0; dw = '0; dp = '0;
    st = s[1];
    if (r) begin
      m_out = 0; m_dead = 0; m_held = 0; m_wait = 0;
      m_addr = '0; m_inst = '0; m_pc = '0; m_valid = 0;
      mem_cnt = 0;
    end else begin
      if (m_held) begin
        if (b) m_held = 0;
        else if (!st) begin
          dlv = 1; dw = m_hw; dp = m_hp; m_held = 0;
        end
      end else if (m_out) begin
        if (ack) begin
          m_out = 0; mem_cnt = 0;
          mem_dly = $urandom_range(1, 4); mem_data = $urandom;
          if (!m_dead && !b) begin
            if (!st) begin dlv = 1; dw = rd; dp = m_addr; end
            else begin m_held = 1; m_hw = rd; m_hp = m_addr; end
          end
        end else begin
          mem_cnt++;
          if (b) m_dead = 1;
        end
      end else if (!b && (!m_wait || o1)) begin
        m_addr = p; m_out = 1; m_dead = 0; m_wait = 0;
      end
      if (b) m_wait = 1;
      if (b) m_valid = 0;
      else if (!st) begin
        m_valid = dlv;
        if (dlv) begin m_inst = dw; m_pc = dp; end
      end
    end
  endtask

  task automatic peek();
    @(posedge clk); #1;
  endtask

  int sr_cnt;

  initial begin
    mem_dly = 1; mem_data = '0; mem_cnt = 0;
    rst = 1; br = 0; stall = '0; pc_i = '0; right_one_i = 0;
    mem_ack_i = 0; mem_rdata_i = '0;
    step(1, 0, 6'd0, 32'h0, 0);
    chk_en = 1;
    step(1, 0, 6'd0, 32'h0, 0);
    peek();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);

    // straight-line fetch
    mem_dly = 1; mem_data = 32'h0000_0013;
    step(0, 0, 6'd0, 32'h04, 0);
    peek();
    chk("sl_addr", mem_addr_o, 32'h04);
    step(0, 0, 6'd0, 32'h08, 0);
    chk("sl_ack_stallreq", {31'd0, last_stallreq}, 32'd0);
    peek();
    chk("sl_inst", inst_o, 32'h13);
    chk("sl_pc", inst_pc_o, 32'h04);
    chk("sl_valid", {31'd0, inst_valid_o}, 32'd1);

    // slow memory
    mem_dly = 4; mem_data = 32'hCAFE_0001;
    step(0, 0, 6'd0, 32'h08, 0);
    sr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 6'd0, 32'h0C, 0);
      sr_cnt += int'(last_stallreq);
    end
    chk("slow_stallreq_cycles", sr_cnt, 3);
    peek();
    chk("slow_inst", inst_o, 32'hCAFE_0001);

    // branch while busy
    mem_dly = 3; mem_data = 32'h0BAD_0BAD;
    step(0, 0, 6'd0, 32'h20, 0);
    step(0, 1, 6'd0, 32'h24, 0);
    step(0, 0, 6'd0, 32'h0C, 0);
    step(0, 0, 6'd0, 32'h0C, 0);
    peek();
    chk("br_squash_valid", {31'd0, inst_valid_o}, 32'd0);
    step(0, 0, 6'd0, 32'h0C, 0);
    peek();
    chk("br_stale_noreq", {31'd0, mem_req_o}, 32'd0);
    step(0, 0, 6'd0, 32'h40, 1);
    peek();
    chk("br_tgt_addr", mem_addr_o, 32'h40);
    mem_dly = 1; mem_data = 32'hAAAA_5555;
    step(0, 0, 6'd0, 32'h44, 0);
    peek();
    chk("br_tgt_pc", inst_pc_o, 32'h40);

    // downstream stall -> hold
    mem_dly = 1; mem_data = 32'hDEAD_BEEF;
    step(0, 0, 6'd0, 32'h44, 0);
    step(0, 0, 6'b000010, 32'h48, 0);
    step(0, 0, 6'b000010, 32'h48, 0);
    chk("hold_stallreq", {31'd0, last_stallreq}, 32'd1);
    step(0, 0, 6'b000010, 32'h48, 0);
    step(0, 0, 6'd0, 32'h48, 0);
    peek();
    chk("hold_inst", inst_o, 32'hDEAD_BEEF);
    chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
    step(0, 0, 6'd0, 32'h48, 1);
    peek();
    chk("hold_one_pulse", {31'd0, inst_valid_o}, 32'd0);

    // simultaneous ack and branch
    mem_dly = 1; mem_data = 32'h1111_1111;
    step(0, 1, 6'd0, 32'h4C, 0);
    peek();
    chk("ackbr_valid", {31'd0, inst_valid_o}, 32'd0);
    step(0, 0, 6'd0, 32'h4C, 0);
    peek();
    chk("ackbr_wait_tgt", {31'd0, mem_req_o}, 32'd0);

    // reset mid-fetch
    mem_dly = 4;
    step(0, 0, 6'd0, 32'h50, 1);
    step(0, 0, 6'd0, 32'h54, 0);
    step(1, 0, 6'd0, 32'h54, 0);
    peek();
    chk("rstmid_req", {31'd0, mem_req_o}, 32'd0);
    chk("rstmid_valid", {31'd0, inst_valid_o}, 32'd0);
    mem_dly = 2;
    step(0, 0, 6'd0, 32'h60, 0);
    peek();
    chk("rstmid_refetch", mem_addr_o, 32'h60);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) == 0,
           6'($urandom) & ($urandom_range(0, 9) < 3 ? 6'h3F : 6'h3D),
           $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
